// File: rtl/dp_pkg.sv
// Shared types for the sequenced datapath: opcodes, shift codes, FSM states.
package dp_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_CMP   = 3'd1,
        OP_AND   = 3'd2,
        OP_MVN   = 3'd3,
        OP_MOV   = 3'd4,
        OP_MOVI  = 3'd5,
        OP_LDM   = 3'd6,
        OP_MOVPC = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'd0,
        SH_LSL1 = 2'd1,
        SH_LSR1 = 2'd2,
        SH_ASR1 = 2'd3
    } shift_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RDA  = 3'd1,
        S_RDB  = 3'd2,
        S_EX   = 3'd3,
        S_WB   = 3'd4
    } state_e;

    // Ops that skip the operand-read/execute states
    function automatic logic is_direct_op(input op_e op);
        return (op == OP_MOVI) || (op == OP_LDM) || (op == OP_MOVPC);
    endfunction

    function automatic logic updates_flags(input op_e op);
        return (op == OP_ADD) || (op == OP_CMP) ||
               (op == OP_AND) || (op == OP_MVN);
    endfunction

endpackage

// File: rtl/dp_alu.sv
// Combinational shifter, B-operand mux, ALU and Z/N/V generation.
module dp_alu
    import dp_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [2:0]        i_op,
    input  logic [1:0]        i_shift,
    input  logic              i_sel_imm,
    input  logic [DATA_W-1:0] i_imm,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_res,
    output logic              o_z,
    output logic              o_n,
    output logic              o_v
);

    localparam int MSB = DATA_W - 1;

    op_e               w_op;
    logic [DATA_W-1:0] w_bs;
    logic [DATA_W-1:0] w_bp;
    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_dif;

    assign w_op  = op_e'(i_op);
    assign w_bp  = i_sel_imm ? i_imm : w_bs;
    assign w_sum = i_a + w_bp;
    assign w_dif = i_a - w_bp;

    always_comb begin
        w_bs = i_b;
        unique case (shift_e'(i_shift))
            SH_NONE: w_bs = i_b;
            SH_LSL1: w_bs = {i_b[MSB-1:0], 1'b0};
            SH_LSR1: w_bs = {1'b0, i_b[MSB:1]};
            SH_ASR1: w_bs = {i_b[MSB], i_b[MSB:1]};
            default: w_bs = i_b;
        endcase
    end

    always_comb begin
        o_res = w_bp;
        o_v   = 1'b0;
        unique case (1'b1)
            (w_op == OP_ADD): begin
                o_res = w_sum;
                o_v   = (i_a[MSB] == w_bp[MSB]) & (w_sum[MSB] != i_a[MSB]);
            end
            // Subtract overflows only when operand signs differ
            (w_op == OP_CMP): begin
                o_res = w_dif;
                o_v   = (i_a[MSB] != w_bp[MSB]) & (w_dif[MSB] != i_a[MSB]);
            end
            (w_op == OP_AND): o_res = i_a & w_bp;
            (w_op == OP_MVN): o_res = ~w_bp;
            default:          o_res = w_bp;
        endcase
    end

    assign o_z = (o_res == '0);
    assign o_n = o_res[MSB];

endmodule

// File: rtl/seq_datapath.sv
// Self-sequencing datapath: command latch, FSM, regfile, A/B/C regs, NZV flags.
module seq_datapath
    import dp_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int NREG   = 8,
    parameter  int PC_W   = 8,
    localparam int AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [AW-1:0]     cmd_rd,
    input  logic [AW-1:0]     cmd_rn,
    input  logic [AW-1:0]     cmd_rm,
    input  logic [1:0]        cmd_shift,
    input  logic              cmd_sel_imm,
    input  logic [DATA_W-1:0] cmd_imm,
    input  logic [DATA_W-1:0] mdata,
    input  logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] result,
    output logic              z_out,
    output logic              n_out,
    output logic              v_out,
    output logic              done
);

    state_e            r_state;
    state_e            w_next;
    op_e               r_op;
    logic [AW-1:0]     r_rd;
    logic [AW-1:0]     r_rn;
    logic [AW-1:0]     r_rm;
    logic [1:0]        r_shift;
    logic              r_sel_imm;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_rf [NREG];
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_c;
    logic              r_z;
    logic              r_n;
    logic              r_v;
    logic              r_done;

    logic              w_accept;
    logic [DATA_W-1:0] w_alu;
    logic              w_z;
    logic              w_n;
    logic              w_v;
    logic [DATA_W-1:0] w_wb;

    assign w_accept = cmd_valid & (r_state == S_IDLE);

    dp_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_op      (r_op),
        .i_shift   (r_shift),
        .i_sel_imm (r_sel_imm),
        .i_imm     (r_imm),
        .i_a       (r_a),
        .i_b       (r_b),
        .o_res     (w_alu),
        .o_z       (w_z),
        .o_n       (w_n),
        .o_v       (w_v)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept)
                    w_next = is_direct_op(op_e'(cmd_op)) ? S_WB : S_RDA;
            end
            S_RDA:   w_next = S_RDB;
            S_RDB:   w_next = S_EX;
            S_EX:    w_next = S_WB;
            S_WB:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_wb = r_c;
        unique case (r_op)
            OP_MOVI:  w_wb = r_imm;
            OP_LDM:   w_wb = mdata;
            OP_MOVPC: w_wb = DATA_W'(pc);
            default:  w_wb = r_c;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= OP_ADD;
            r_rd      <= '0;
            r_rn      <= '0;
            r_rm      <= '0;
            r_shift   <= '0;
            r_sel_imm <= 1'b0;
            r_imm     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_c       <= '0;
            r_z       <= 1'b0;
            r_n       <= 1'b0;
            r_v       <= 1'b0;
            r_done    <= 1'b0;
            for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_op      <= op_e'(cmd_op);
                r_rd      <= cmd_rd;
                r_rn      <= cmd_rn;
                r_rm      <= cmd_rm;
                r_shift   <= cmd_shift;
                r_sel_imm <= cmd_sel_imm;
                r_imm     <= cmd_imm;
            end
            if (r_state == S_RDA) r_a <= r_rf[r_rn];
            if (r_state == S_RDB) r_b <= r_rf[r_rm];
            if (r_state == S_EX) begin
                if (r_op != OP_CMP) r_c <= w_alu;
                if (updates_flags(r_op)) begin
                    r_z <= w_z;
                    r_n <= w_n;
                    r_v <= w_v;
                end
            end
            // CMP retires without touching the regfile
            if (r_state == S_WB) begin
                if (r_op != OP_CMP) r_rf[r_rd] <= w_wb;
                r_done <= 1'b1;
            end
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign result    = r_c;
    assign z_out     = r_z;
    assign n_out     = r_n;
    assign v_out     = r_v;
    assign done      = r_done;

endmodule

// File: tb/tb_seq_datapath.sv
// Directed bench for seq_datapath: 16-bit default instance plus a 32-bit/16-reg one.
module tb_seq_datapath;
    import dp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [2:0]  cmd_rd, cmd_rn, cmd_rm;
    logic [1:0]  cmd_shift;
    logic        cmd_sel_imm;
    logic [15:0] cmd_imm;
    logic [15:0] mdata;
    logic [7:0]  pc;
    logic [15:0] result;
    logic        z_out, n_out, v_out, done;

    logic        c32_valid;
    logic        c32_ready;
    logic [2:0]  c32_op;
    logic [3:0]  c32_rd, c32_rn, c32_rm;
    logic [1:0]  c32_shift;
    logic        c32_sel;
    logic [31:0] c32_imm;
    logic [31:0] c32_mdata;
    logic [7:0]  c32_pc;
    logic [31:0] c32_res;
    logic        c32_z, c32_n, c32_v, c32_done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_datapath u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_rd      (cmd_rd),
        .cmd_rn      (cmd_rn),
        .cmd_rm      (cmd_rm),
        .cmd_shift   (cmd_shift),
        .cmd_sel_imm (cmd_sel_imm),
        .cmd_imm     (cmd_imm),
        .mdata       (mdata),
        .pc          (pc),
        .result      (result),
        .z_out       (z_out),
        .n_out       (n_out),
        .v_out       (v_out),
        .done        (done)
    );

    seq_datapath #(
        .DATA_W (32),
        .NREG   (16),
        .PC_W   (8)
    ) u_dut32 (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (c32_valid),
        .cmd_ready   (c32_ready),
        .cmd_op      (c32_op),
        .cmd_rd      (c32_rd),
        .cmd_rn      (c32_rn),
        .cmd_rm      (c32_rm),
        .cmd_shift   (c32_shift),
        .cmd_sel_imm (c32_sel),
        .cmd_imm     (c32_imm),
        .mdata       (c32_mdata),
        .pc          (c32_pc),
        .result      (c32_res),
        .z_out       (c32_z),
        .n_out       (c32_n),
        .v_out       (c32_v),
        .done        (c32_done)
    );

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  rd, rn, rm;
        logic [1:0]  sh;
        logic        sel;
        logic [15:0] imm;
        logic [15:0] res;
        logic        z, n, v;
        int          lat;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] op, input logic [2:0] rd,
                                input logic [2:0] rn, input logic [2:0] rm,
                                input logic [1:0] sh, input logic sel,
                                input logic [15:0] imm, input logic [15:0] res,
                                input logic z, input logic n, input logic v);
        vec_t t;
        t.op  = op;  t.rd = rd; t.rn = rn; t.rm = rm;
        t.sh  = sh;  t.sel = sel; t.imm = imm; t.res = res;
        t.z   = z;   t.n = n;   t.v = v;
        t.lat = (op >= 3'd5) ? 2 : 5;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run16(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        cmd_op = v.op; cmd_rd = v.rd; cmd_rn = v.rn; cmd_rm = v.rm;
        cmd_shift = v.sh; cmd_sel_imm = v.sel; cmd_imm = v.imm;
        cmd_valid = 1'b1;
        check({tag, " ready"}, cmd_ready, 1);
        @(posedge clk); #1;
        // Scramble fields after accept: the DUT must use its latched copy
        cmd_valid = 1'b0;
        cmd_op = ~v.op; cmd_rd = ~v.rd; cmd_rn = ~v.rn; cmd_rm = ~v.rm;
        cmd_shift = ~v.sh; cmd_sel_imm = ~v.sel; cmd_imm = ~v.imm;
        lat = 1;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, lat, v.lat);
        check({tag, " result"}, result, v.res);
        check({tag, " zflag"}, z_out, v.z);
        check({tag, " nflag"}, n_out, v.n);
        check({tag, " vflag"}, v_out, v.v);
        @(posedge clk); #1;
        check({tag, " done pulse"}, done, 0);
    endtask

    task automatic run32(input logic [2:0] op, input logic [3:0] rd,
                         input logic [3:0] rn, input logic [3:0] rm,
                         input logic sel, input logic [31:0] imm,
                         input string tag, input logic [31:0] eres,
                         input logic ez, input logic en, input logic ev);
        int lat;
        @(negedge clk);
        c32_op = op; c32_rd = rd; c32_rn = rn; c32_rm = rm;
        c32_shift = 2'd0; c32_sel = sel; c32_imm = imm; c32_valid = 1'b1;
        check({tag, " ready"}, c32_ready, 1);
        @(posedge clk); #1;
        c32_valid = 1'b0;
        lat = 1;
        while (!c32_done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, lat, (op >= 3'd5) ? 2 : 5);
        check({tag, " result"}, c32_res, eres);
        check({tag, " zflag"}, c32_z, ez);
        check({tag, " nflag"}, c32_n, en);
        check({tag, " vflag"}, c32_v, ev);
    endtask

    vec_t vt[$];

    initial begin
        rst_n = 1'b0;
        cmd_valid = 0; cmd_op = 0; cmd_rd = 0; cmd_rn = 0; cmd_rm = 0;
        cmd_shift = 0; cmd_sel_imm = 0; cmd_imm = 0; mdata = 0; pc = 0;
        c32_valid = 0; c32_op = 0; c32_rd = 0; c32_rn = 0; c32_rm = 0;
        c32_shift = 0; c32_sel = 0; c32_imm = 0; c32_mdata = 0; c32_pc = 0;

        // Reset values
        #12;
        check("rst ready", cmd_ready, 1);
        check("rst result", result, 0);
        check("rst flags", {z_out, n_out, v_out}, 0);
        check("rst done", done, 0);
        check("rst32 result", c32_res, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Abort an ADD in S_EX with reset
        run16(mk(OP_MOVI, 1, 0, 0, 0, 0, 16'd5, 16'h0, 0, 0, 0), "pre movi");
        @(negedge clk);
        cmd_op = OP_ADD; cmd_rd = 3; cmd_rn = 1; cmd_rm = 1;
        cmd_shift = 0; cmd_sel_imm = 0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort done", done, 0);
        check("abort ready", cmd_ready, 1);
        check("abort result", result, 0);
        @(posedge clk); #1;
        check("abort done held", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort no late done", done, 0);

        vt.push_back(mk(OP_MOV,  1, 0, 1, 0, 0, 16'h0,    16'h0000, 0, 0, 0));
        vt.push_back(mk(OP_MOV,  3, 0, 3, 0, 0, 16'h0,    16'h0000, 0, 0, 0));
        vt.push_back(mk(OP_MOVI, 1, 0, 0, 0, 0, 16'd5,    16'h0000, 0, 0, 0));
        vt.push_back(mk(OP_MOVI, 2, 0, 0, 0, 0, 16'd3,    16'h0000, 0, 0, 0));
        vt.push_back(mk(OP_ADD,  3, 1, 2, 1, 0, 16'h0,    16'h000B, 0, 0, 0));
        vt.push_back(mk(OP_MOV,  3, 0, 3, 0, 0, 16'h0,    16'h000B, 0, 0, 0));
        vt.push_back(mk(OP_MOVI, 0, 0, 0, 0, 0, 16'h7FFF, 16'h000B, 0, 0, 0));
        vt.push_back(mk(OP_MOVI, 1, 0, 0, 0, 0, 16'h0001, 16'h000B, 0, 0, 0));
        vt.push_back(mk(OP_ADD,  2, 0, 1, 0, 0, 16'h0,    16'h8000, 0, 1, 1));
        vt.push_back(mk(OP_CMP,  2, 1, 0, 0, 0, 16'h0,    16'h8000, 0, 1, 0));
        vt.push_back(mk(OP_MOV,  2, 0, 2, 0, 0, 16'h0,    16'h8000, 0, 1, 0));
        vt.push_back(mk(OP_MOVI, 4, 0, 0, 0, 0, 16'h8002, 16'h8000, 0, 1, 0));
        vt.push_back(mk(OP_MOV,  5, 0, 4, 3, 0, 16'h0,    16'hC001, 0, 1, 0));
        vt.push_back(mk(OP_MVN,  6, 0, 4, 0, 0, 16'h0,    16'h7FFD, 0, 0, 0));
        vt.push_back(mk(OP_MOV,  5, 0, 5, 0, 0, 16'h0,    16'hC001, 0, 0, 0));
        vt.push_back(mk(OP_CMP,  7, 0, 4, 0, 0, 16'h0,    16'hC001, 0, 1, 1));
        vt.push_back(mk(OP_CMP,  7, 1, 1, 0, 0, 16'h0,    16'hC001, 1, 0, 0));
        vt.push_back(mk(OP_AND,  7, 4, 0, 0, 1, 16'h00F0, 16'h0000, 1, 0, 0));
        vt.push_back(mk(OP_ADD,  0, 3, 4, 2, 0, 16'h0,    16'h400C, 0, 0, 0));
        vt.push_back(mk(OP_MOV,  6, 0, 6, 0, 0, 16'h0,    16'h7FFD, 0, 0, 0));
        vt.push_back(mk(OP_MOV,  1, 0, 7, 1, 1, 16'h1234, 16'h1234, 0, 0, 0));
        vt.push_back(mk(OP_MOV,  1, 0, 1, 0, 0, 16'h0,    16'h1234, 0, 0, 0));
        for (int i = 0; i < vt.size(); i++)
            run16(vt[i], $sformatf("vec%0d", i));

        // Back-to-back LDM then MOVPC with cmd_valid held high
        @(negedge clk);
        cmd_op = OP_LDM; cmd_rd = 7; cmd_sel_imm = 0; mdata = 16'hBEEF;
        pc = 8'h42; cmd_valid = 1'b1;
        check("b2b ldm ready", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_op = OP_MOVPC; cmd_rd = 0;
        check("b2b ldm busy", cmd_ready, 0);
        @(posedge clk); #1;
        check("b2b ldm done", done, 1);
        check("b2b ready in done", cmd_ready, 1);
        @(posedge clk); #1;
        check("b2b movpc accepted", cmd_ready, 0);
        check("b2b done low", done, 0);
        cmd_valid = 1'b0;
        mdata = 16'h0;
        @(posedge clk); #1;
        check("b2b movpc done", done, 1);
        run16(mk(OP_MOV, 7, 0, 7, 0, 0, 16'h0, 16'hBEEF, 0, 0, 0), "rd r7");
        run16(mk(OP_MOV, 0, 0, 0, 0, 0, 16'h0, 16'h0042, 0, 0, 0), "rd r0");

        // Wide instance: 0 + (-1) in R15, read back through R14
        run32(OP_ADD, 15, 15, 0, 1, 32'hFFFF_FFFF, "w32 add",
              32'hFFFF_FFFF, 0, 1, 0);
        run32(OP_MOV, 14, 0, 15, 0, 32'h0, "w32 mov",
              32'hFFFF_FFFF, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
